// File: rtl/rv_dbus_arb_pkg.sv
//   +--------------------------------------------------------------------+
//   | Module   : rv_dbus_arb_pkg                                         |
//   | Purpose  : Shared types for the dpram port-B data-bus arbiter.     |
//   |            u32_t / u4_t bus types, arbiter state enum and master   |
//   |            identifiers used by the round-robin "last" register.    |
//   | Ports    : none (package)                                          |
//   | Macros   : none here; RV_ARB_LOCK_EN is consumed by rv_dbus_arb.   |
//   | Revision : 1.0  initial release                                    |
//   +--------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

package rv_dbus_arb_pkg;

   typedef logic [31:0] u32_t;
   typedef logic [3:0]  u4_t;

   // LOCK1 is only reachable when the lock feature is built in.
   typedef enum logic [0:0] {
      ARB   = 1'b0,
      LOCK1 = 1'b1
   } arb_state_t;

   // Master identifiers as held in the round-robin "last granted" register.
   localparam logic c_M0 = 1'b0;
   localparam logic c_M1 = 1'b1;

endpackage : rv_dbus_arb_pkg

`default_nettype wire

// File: rtl/rv_dbus_arb.sv
//   +--------------------------------------------------------------------+
//   | Module   : rv_dbus_arb                                             |
//   | Purpose  : Two-master arbiter for dpram port B. The core (m0) and a |
//   |            secondary master (m1, DMA / loader) share the RAM; the  |
//   |            loser is stalled through its rdy output. Grant is       |
//   |            combinational (no wait state for a lone requester),     |
//   |            round-robin under contention.                           |
//   | Ports    : clk_i, xreset_i (sync, active-low)                      |
//   |            m0_*_i / m0_dr_o / m0_rdy_o     core data port          |
//   |            m1_*_i / m1_dr_o / m1_rdy_o / m1_rvalid_o  2nd master   |
//   |            m1_lock_i   exclusive-ownership request (lock build)    |
//   |            s_en_o, s_we_o, s_adr_o, s_dw_o, s_dr_i   dpram port B  |
//   | Macros   : RV_ARB_LOCK_EN  adds m1_lock_i and the LOCK1 state      |
//   | Revision : 1.0  initial release                                    |
//   +--------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module rv_dbus_arb
   import rv_dbus_arb_pkg::*;
#(
   parameter int AW = 13
) (
   input  logic          clk_i,
   input  logic          xreset_i,
   // core data port
   input  u32_t          m0_adr_i,
   input  logic          m0_re_i,
   input  u4_t           m0_we_i,
   input  u32_t          m0_dw_i,
   output u32_t          m0_dr_o,
   output logic          m0_rdy_o,
   // secondary master
   input  u32_t          m1_adr_i,
   input  logic          m1_re_i,
   input  u4_t           m1_we_i,
   input  u32_t          m1_dw_i,
   output u32_t          m1_dr_o,
   output logic          m1_rdy_o,
   output logic          m1_rvalid_o,
`ifdef RV_ARB_LOCK_EN
   input  logic          m1_lock_i,
`endif
   // dpram port B
   output logic          s_en_o,
   output u4_t           s_we_o,
   output logic [AW-1:0] s_adr_o,
   output u32_t          s_dw_o,
   input  u32_t          s_dr_i
);

   // Round-robin pick, returns {grant_m1, grant_m0}. Under contention the
   // master that was not granted last wins.
   function automatic logic [1:0] rr_pick(input logic req0, input logic req1,
                                          input logic last);
      if (req0 && req1) begin
         return (last == c_M1) ? 2'b01 : 2'b10;
      end
      return {req1, req0};
   endfunction

   logic       last_q, last_d;
   logic       rd_pend_q, rd_pend_d;
   logic       rd_owner_q, rd_owner_d;

   logic       w_m0_req, w_m1_req;
   logic       w_m0_rd, w_m1_rd;
   logic [1:0] w_pick;
   logic       w_gnt0, w_gnt1;

   // Byte-lane bits and bits above the RAM window are not decoded here.
   logic       w_unused_adr;
   assign w_unused_adr = ^{m0_adr_i[31:AW+2], m0_adr_i[1:0],
                           m1_adr_i[31:AW+2], m1_adr_i[1:0]};

   assign w_m0_req = m0_re_i | (m0_we_i != 4'h0);
   assign w_m1_req = m1_re_i | (m1_we_i != 4'h0);
   // Any byte enable turns the access into a write, even with re set.
   assign w_m0_rd  = m0_re_i & (m0_we_i == 4'h0);
   assign w_m1_rd  = m1_re_i & (m1_we_i == 4'h0);

`ifdef RV_ARB_LOCK_EN
   arb_state_t state_q, state_d;
   logic       w_lock_hold;

   // The lock only holds while m1 keeps m1_lock_i high; the cycle it drops
   // is already arbitrated normally.
   assign w_lock_hold = (state_q == LOCK1) & m1_lock_i;

   always_comb begin
      w_pick = rr_pick(w_m0_req, w_m1_req, last_q);
      if (w_lock_hold) begin
         w_pick = {w_m1_req, 1'b0};
      end
   end

   assign state_d = (m1_lock_i && ((state_q == LOCK1) || w_gnt1)) ? LOCK1 : ARB;

   always_ff @(posedge clk_i) begin
      if (!xreset_i) begin
         state_q <= ARB;
      end else begin
         state_q <= state_d;
      end
   end
`else
   assign w_pick = rr_pick(w_m0_req, w_m1_req, last_q);
`endif

   // Nothing is granted while reset is held, regardless of requests.
   assign w_gnt0   = xreset_i & w_pick[0];
   assign w_gnt1   = xreset_i & w_pick[1];

   assign m0_rdy_o = w_gnt0;
   assign m1_rdy_o = w_gnt1;

   // Slave mux straight from the granted master.
   always_comb begin
      s_en_o  = w_gnt0 | w_gnt1;
      s_we_o  = 4'h0;
      s_adr_o = m0_adr_i[AW+1:2];
      s_dw_o  = m0_dw_i;
      if (w_gnt1) begin
         s_we_o  = m1_we_i;
         s_adr_o = m1_adr_i[AW+1:2];
         s_dw_o  = m1_dw_i;
      end else if (w_gnt0) begin
         s_we_o  = m0_we_i;
      end
   end

   always_comb begin
      last_d = last_q;
      if (w_gnt0) begin
         last_d = c_M0;
      end
      if (w_gnt1) begin
         last_d = c_M1;
      end
      rd_pend_d  = (w_gnt0 & w_m0_rd) | (w_gnt1 & w_m1_rd);
      rd_owner_d = w_gnt1;
   end

   always_ff @(posedge clk_i) begin
      if (!xreset_i) begin
         last_q     <= c_M1;     // m0 wins the first contention
         rd_pend_q  <= 1'b0;
         rd_owner_q <= c_M0;
      end else begin
         last_q     <= last_d;
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   // RAM read data is shared; m0 samples it by fixed one-cycle latency,
   // m1 gets an explicit valid. Reset masks a read still in flight.
   assign m0_dr_o     = s_dr_i;
   assign m1_dr_o     = s_dr_i;
   assign m1_rvalid_o = xreset_i & rd_pend_q & (rd_owner_q == c_M1);

endmodule : rv_dbus_arb

`default_nettype wire

// File: doc/rv_dbus_arb.md
# rv_dbus_arb

Two-master arbiter for the data port (port B) of the shared 32 kB instruction/data `dpram`. It lets a second bus master, such as a DMA or a UART program loader, share the RAM with the `rv_core` data port. It works by stalling the losing master through its `rdy` input. It sits between the core data bus, already qualified by the RAM address window, and the `dpram` port-B pins: `enaB`, `weB`, `addrB`, `dinB` and `doutB`.

## Interface
Parameters:
- `AW`, default 13: RAM word-address width; the RAM covers 2^AW 32-bit words.

Ports:
- `clk`  in  1: single clock for the block.
- `xreset`  in  1: reset, synchronous, active-low.
- `m0_adr`  in  32: core byte address; bits [AW+1:2] are used.
- `m0_re`  in  1: core read request.
- `m0_we`  in  4: core byte write enables.
- `m0_dw`  in  32: core write data.
- `m0_dr`  out  32: core read data.
- `m0_rdy`  out  1: core access accepted this cycle.
- `m1_adr`, `m1_re`, `m1_we`, `m1_dw`, `m1_dr`, `m1_rdy`: same as the m0 ports, for the secondary master.
- `m1_rvalid`  out  1: m1 read data valid on `m1_dr`.
- `m1_lock`  in  1: m1 requests exclusive ownership. Present only when `RV_ARB_LOCK_EN` is defined.
- `s_en`  out  1: RAM port enable, to `enaB`.
- `s_we`  out  4: to `weB`.
- `s_adr`  out  AW: to `addrB`.
- `s_dw`  out  32: to `dinB`.
- `s_dr`  in  32: from `doutB`; data is valid one cycle after `s_en`.

## Operation
- Request: `mN_req = mN_re | (mN_we != 0)`.
- Accept: an access is accepted in the cycle where `mN_req & mN_rdy` is true.
- Master obligation: while `mN_rdy` is low, the master holds its address, data and enables stable.
- Write precedence: if `re` and `we` are both asserted, the access is a write. No read data is returned for it.
- Grant with one requester: that master is granted in the same cycle, with no wait state.
- Grant with both requesting: the master that was not last granted wins (round-robin).
  - The `last` register updates on every accepted access.
- Slave mux: `s_en`, `s_we`, `s_adr` and `s_dw` come combinationally from the granted master.
  - With no grant: `s_en` = 0 and `s_we` = 0.
- Read return:
  - `m0_dr` = `m1_dr` = `s_dr`.
  - A registered `rd_owner`/`rd_pend` pair records which master's read was accepted.
  - `m1_rvalid` is high for one cycle, the cycle after an m1 read is accepted.
  - The core samples `m0_dr` the cycle after its accepted read. This is unchanged from the direct core-to-RAM path.
- State machine:
  - ARB: round-robin as above.
  - LOCK1 (`RV_ARB_LOCK_EN` only):
    - Entered when an m1 access is accepted with `m1_lock` = 1.
    - While in LOCK1, only m1 is granted and `m0_rdy` = 0.
    - LOCK1 is left in the first cycle where `m1_lock` = 0. That cycle is already arbitrated in ARB.
- Reset: while `xreset` = 0, all of the following hold:
  - `m0_rdy` = 0, `m1_rdy` = 0, `s_en` = 0, `s_we` = 0, `m1_rvalid` = 0.
  - `rd_pend` = 0 and the state is ARB.
  - `last` = m1, so m0 wins the first contention.
- Reset mid-operation:
  - Any read in flight is dropped; no `m1_rvalid` follows reset release.
  - A held lock is released.

## Timing
- Grant path is combinational: request to `rdy`/`s_en` is same-cycle. There is no registered output stage.
- Read latency: accept cycle T, data on `mN_dr` in T+1, `m1_rvalid` in T+1.
- Back-to-back contention: grants alternate m0, m1, m0, … Each master gets 50% of the bandwidth with a worst-case wait of 1 cycle.
- Sustained single master: one access per cycle, with reads pipelined.
- Locked m1: m0 wait is unbounded; the m1 master bounds lock duration by contract.

## Configuration
- `RV_ARB_LOCK_EN` defined:
  - The `m1_lock` port exists and the LOCK1 state is built.
  - Used for read-modify-write and atomic block loads by the loader.
- `RV_ARB_LOCK_EN` undefined:
  - No `m1_lock` port and no LOCK1 state.
  - Arbitration is pure round-robin.

## Structure
- Types come from the shared types package: `u32_t`, `u4_t`.
- The block adds an `arb_state_t` enum (ARB, LOCK1) to the same package.
- Implementation is a single module with no sub-module.
- The round-robin pick is a small function local to the module.

## Test plan
- Solo m0: read 0x0000_0100 with RAM word 0x40 = 0x1234_5678.
  - `m0_rdy` = 1 the same cycle, `s_adr` = 0x40.
  - `m0_dr` = 0x1234_5678 the next cycle.
- Contention: both masters request continuously for 6 cycles after reset.
  - Grants are m0, m1, m0, m1, m0, m1.
  - `m1_rvalid` pulses one cycle after each m1 read grant.
- Write precedence: m1 drives `re` = 1 with `we` = 4'b0011 and `dw` = 0xAAAA_5555 at 0x20.
  - RAM word 8 low half becomes 0x5555.
  - `m1_rvalid` stays 0.
- Lock (`RV_ARB_LOCK_EN`): m1 locks and performs 3 accesses while m0 requests continuously.
  - `m0_rdy` stays 0 for all 3 accesses.
  - m0 is granted in the cycle `m1_lock` falls.
- Reset mid-read: accept an m1 read, then pull `xreset` low in the next cycle.
  - `m1_rvalid`, `s_en` and both `rdy` outputs are 0.
  - After release, m0 wins the first contention.
- Idle: no requests for 10 cycles.
  - `s_en` = 0 and `s_we` = 0 throughout.
  - `last` is unchanged.
